// File: rtl/vga_pkg.sv
// Timing constants and coordinate types for the 800x600@60 raster generator.
package vga_pkg;

    localparam int unsigned H_VISIBLE = 800;
    localparam int unsigned H_FRONT   = 40;
    localparam int unsigned H_SYNC    = 128;
    localparam int unsigned H_BACK    = 88;
    localparam int unsigned V_VISIBLE = 600;
    localparam int unsigned V_FRONT   = 1;
    localparam int unsigned V_SYNC    = 4;
    localparam int unsigned V_BACK    = 23;
    localparam bit          H_SYNC_POL = 1'b1;
    localparam bit          V_SYNC_POL = 1'b1;

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    typedef logic [10:0] h_coord_t;
    typedef logic [9:0]  v_coord_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-advance input and raster outputs of the timing generator.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic     i_pix_en;
    h_coord_t o_h_coord;
    v_coord_t o_v_coord;
    logic     o_disp_enbl;
    logic     o_hsync;
    logic     o_vsync;
    logic     o_frame_start;
    logic     o_line_start;
    logic     o_vblank_start;

    modport master (
        input  i_pix_en,
        output o_h_coord, o_v_coord, o_disp_enbl, o_hsync, o_vsync,
               o_frame_start, o_line_start, o_vblank_start
    );

    modport slave (
        output i_pix_en,
        input  o_h_coord, o_v_coord, o_disp_enbl, o_hsync, o_vsync,
               o_frame_start, o_line_start, o_vblank_start
    );

endinterface

// File: rtl/vga_axis_counter.sv
// Modulo counter with enable; resets to MODULUS-1 so the first enable lands on 0.
module vga_axis_counter #(
    parameter int unsigned WIDTH   = 11,
    parameter int unsigned MODULUS = 1056
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_nxt,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    // wrap is qualified by en so it marks the exact edge on which 0 is loaded
    assign wrap = en && (count == LAST);

    always_comb begin
        count_nxt = count;
        if (en) begin
            count_nxt = (count == LAST) ? '0 : count + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= LAST;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters plus registered sync, display-enable and strobes.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE  = vga_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT    = vga_pkg::H_FRONT,
    parameter int unsigned H_SYNC     = vga_pkg::H_SYNC,
    parameter int unsigned H_BACK     = vga_pkg::H_BACK,
    parameter int unsigned V_VISIBLE  = vga_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT    = vga_pkg::V_FRONT,
    parameter int unsigned V_SYNC     = vga_pkg::V_SYNC,
    parameter int unsigned V_BACK     = vga_pkg::V_BACK,
    parameter bit          H_SYNC_POL = vga_pkg::H_SYNC_POL,
    parameter bit          V_SYNC_POL = vga_pkg::V_SYNC_POL
) (
    input logic               i_clk,
    input logic               i_rst_n,
    vga_timing_gen_if.master  bus
);
    import vga_pkg::*;

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_range_err
            $error("vga_timing_gen: H_TOTAL=%0d or V_TOTAL=%0d exceeds counter range",
                   H_TOTAL, V_TOTAL);
        end
    endgenerate

    localparam h_coord_t H_ACT_END = h_coord_t'(H_VISIBLE);
    localparam h_coord_t HS_BEG    = h_coord_t'(H_VISIBLE + H_FRONT);
    localparam h_coord_t HS_END    = h_coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam v_coord_t V_ACT_END = v_coord_t'(V_VISIBLE);
    localparam v_coord_t VS_BEG    = v_coord_t'(V_VISIBLE + V_FRONT);
    localparam v_coord_t VS_END    = v_coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

    logic     pix_en;
    h_coord_t h_q, h_nxt;
    v_coord_t v_q, v_nxt;
    logic     h_wrap, v_wrap;

    assign pix_en = bus.i_pix_en;

    vga_axis_counter #(
        .WIDTH   ($bits(h_coord_t)),
        .MODULUS (H_TOTAL)
    ) u_h_cnt (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .en        (pix_en),
        .count     (h_q),
        .count_nxt (h_nxt),
        .wrap      (h_wrap)
    );

    vga_axis_counter #(
        .WIDTH   ($bits(v_coord_t)),
        .MODULUS (V_TOTAL)
    ) u_v_cnt (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .en        (pix_en && h_wrap),
        .count     (v_q),
        .count_nxt (v_nxt),
        .wrap      (v_wrap)
    );

    // Decode from the next-state counters so flags line up with the registered coordinates
    logic disp_nxt, hsync_nxt, vsync_nxt;

    always_comb begin
        disp_nxt  = (h_nxt < H_ACT_END) && (v_nxt < V_ACT_END);
        hsync_nxt = ((h_nxt >= HS_BEG) && (h_nxt < HS_END)) ? H_SYNC_POL : !H_SYNC_POL;
        vsync_nxt = ((v_nxt >= VS_BEG) && (v_nxt < VS_END)) ? V_SYNC_POL : !V_SYNC_POL;
    end

    logic disp_q, hsync_q, vsync_q;
    logic frame_q, line_q, vblank_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            disp_q   <= 1'b0;
            hsync_q  <= !H_SYNC_POL;
            vsync_q  <= !V_SYNC_POL;
            frame_q  <= 1'b0;
            line_q   <= 1'b0;
            vblank_q <= 1'b0;
        end else begin
            frame_q  <= h_wrap && v_wrap;
            line_q   <= h_wrap;
            vblank_q <= h_wrap && (v_nxt == V_ACT_END);
            if (pix_en) begin
                disp_q  <= disp_nxt;
                hsync_q <= hsync_nxt;
                vsync_q <= vsync_nxt;
            end
        end
    end

    assign bus.o_h_coord      = h_q;
    assign bus.o_v_coord      = v_q;
    assign bus.o_disp_enbl    = disp_q;
    assign bus.o_hsync        = hsync_q;
    assign bus.o_vsync        = vsync_q;
    assign bus.o_frame_start  = frame_q;
    assign bus.o_line_start   = line_q;
    assign bus.o_vblank_start = vblank_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size mode for line timing, reduced geometry for frame-level behaviour.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [10:0] h;
        logic [9:0]  v;
        logic de, hs, vs, fs, ls, vb;
    } out_t;

    typedef struct {
        int unsigned cycles;
        bit          en;
        out_t        exp;
    } vec_t;

    // Reduced geometry keeps whole frames short
    localparam int unsigned S_HV = 16, S_HF = 4, S_HS = 8, S_HB = 4;
    localparam int unsigned S_VV = 12, S_VF = 1, S_VS = 2, S_VB = 3;
    localparam bit          S_HPOL = 1'b0, S_VPOL = 1'b1;
    localparam int unsigned S_HT  = S_HV + S_HF + S_HS + S_HB;
    localparam int unsigned S_VT  = S_VV + S_VF + S_VS + S_VB;
    localparam int unsigned S_TOT = S_HT * S_VT;

    logic clk = 1'b0;
    logic rst_f_n, rst_s_n;
    always #5 clk = ~clk;

    vga_timing_gen_if bus_f ();
    vga_timing_gen_if bus_s ();

    vga_timing_gen u_full (
        .i_clk   (clk),
        .i_rst_n (rst_f_n),
        .bus     (bus_f.master)
    );

    vga_timing_gen #(
        .H_VISIBLE  (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_VISIBLE  (S_VV), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
        .H_SYNC_POL (S_HPOL),
        .V_SYNC_POL (S_VPOL)
    ) u_small (
        .i_clk   (clk),
        .i_rst_n (rst_s_n),
        .bus     (bus_s.master)
    );

    int unsigned n_checks = 0, n_fail = 0;
    int unsigned cyc = 0;
    int unsigned idx_s;   // raster position as a linear pixel index
    bit          pul_s;   // a pixel advance happened on the last edge

    function automatic out_t mk(input int unsigned h, input int unsigned v,
                                input bit de, input bit hs, input bit vs,
                                input bit fs, input bit ls, input bit vb);
        out_t o;
        o.h = 11'(h); o.v = 10'(v);
        o.de = de; o.hs = hs; o.vs = vs; o.fs = fs; o.ls = ls; o.vb = vb;
        return o;
    endfunction

    function automatic out_t get_f();
        return mk(bus_f.o_h_coord, bus_f.o_v_coord, bus_f.o_disp_enbl, bus_f.o_hsync,
                  bus_f.o_vsync, bus_f.o_frame_start, bus_f.o_line_start, bus_f.o_vblank_start);
    endfunction

    function automatic out_t get_s();
        return mk(bus_s.o_h_coord, bus_s.o_v_coord, bus_s.o_disp_enbl, bus_s.o_hsync,
                  bus_s.o_vsync, bus_s.o_frame_start, bus_s.o_line_start, bus_s.o_vblank_start);
    endfunction

    function automatic out_t model_s();
        int unsigned h, v;
        bit hs_win, vs_win, at_line;
        h = idx_s % S_HT;
        v = idx_s / S_HT;
        hs_win  = (h >= S_HV + S_HF) && (h < S_HV + S_HF + S_HS);
        vs_win  = (v >= S_VV + S_VF) && (v < S_VV + S_VF + S_VS);
        at_line = pul_s && (h == 0);
        return mk(h, v, (h < S_HV) && (v < S_VV),
                  hs_win ? S_HPOL : !S_HPOL, vs_win ? S_VPOL : !S_VPOL,
                  at_line && (v == 0), at_line, at_line && (v == S_VV));
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got h=%0d v=%0d de=%b hs=%b vs=%b fs=%b ls=%b vb=%b, expected h=%0d v=%0d de=%b hs=%b vs=%b fs=%b ls=%b vb=%b",
                     name, $time, act.h, act.v, act.de, act.hs, act.vs, act.fs, act.ls, act.vb,
                     exp.h, exp.v, exp.de, exp.hs, exp.vs, exp.fs, exp.ls, exp.vb);
        end
    endtask

    task automatic check_val(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step_f(input bit en);
        bus_f.i_pix_en = en;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_s(input bit en);
        bus_s.i_pix_en = en;
        @(posedge clk);
        if (rst_s_n) begin
            pul_s = en;
            if (en) idx_s = (idx_s + 1) % S_TOT;
        end else begin
            pul_s = 1'b0;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[12];
        int unsigned last_fs, seen, vb_cnt, guard, fs_cnt;

        // Line 0/1 of the full-size mode, i_pix_en held high except on hold entries
        vecs[0]  = '{1,   1'b1, mk(0,    0, 1, 0, 0, 1, 1, 0)};
        vecs[1]  = '{1,   1'b1, mk(1,    0, 1, 0, 0, 0, 0, 0)};
        vecs[2]  = '{2,   1'b0, mk(1,    0, 1, 0, 0, 0, 0, 0)};
        vecs[3]  = '{798, 1'b1, mk(799,  0, 1, 0, 0, 0, 0, 0)};
        vecs[4]  = '{1,   1'b1, mk(800,  0, 0, 0, 0, 0, 0, 0)};
        vecs[5]  = '{40,  1'b1, mk(840,  0, 0, 1, 0, 0, 0, 0)};
        vecs[6]  = '{127, 1'b1, mk(967,  0, 0, 1, 0, 0, 0, 0)};
        vecs[7]  = '{1,   1'b1, mk(968,  0, 0, 0, 0, 0, 0, 0)};
        vecs[8]  = '{87,  1'b1, mk(1055, 0, 0, 0, 0, 0, 0, 0)};
        vecs[9]  = '{1,   1'b1, mk(0,    1, 1, 0, 0, 0, 1, 0)};
        vecs[10] = '{1,   1'b0, mk(0,    1, 1, 0, 0, 0, 0, 0)};
        vecs[11] = '{1,   1'b1, mk(1,    1, 1, 0, 0, 0, 0, 0)};

        rst_f_n = 1'b0;
        rst_s_n = 1'b0;
        bus_f.i_pix_en = 1'b1;
        bus_s.i_pix_en = 1'b0;
        idx_s = S_TOT - 1;
        pul_s = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_full", get_f(), mk(1055, 627, 0, 0, 0, 0, 0, 0));
        rst_f_n = 1'b1;
        foreach (vecs[i]) begin
            repeat (vecs[i].cycles) step_f(vecs[i].en);
            check($sformatf("line_vec%0d", i), get_f(), vecs[i].exp);
        end

        // Async reset of the full-size mode mid-line, no clock edge in between
        repeat (499) step_f(1'b1);
        check("pre_reset_full", get_f(), mk(500, 1, 1, 0, 0, 0, 0, 0));
        #2 rst_f_n = 1'b0;
        #1 check("async_reset_full", get_f(), mk(1055, 627, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_f_n = 1'b1;
        step_f(1'b1);
        check("restart_full", get_f(), mk(0, 0, 1, 0, 0, 1, 1, 0));
        bus_f.i_pix_en = 1'b0;

        // Reduced geometry: constant i_pix_en over two frames
        check("reset_small", get_s(), model_s());
        rst_s_n = 1'b1;
        last_fs = 0; seen = 0; vb_cnt = 0;
        for (int i = 0; i < int'(2 * S_TOT + 5); i++) begin
            step_s(1'b1);
            check("const_en", get_s(), model_s());
            if (bus_s.o_vblank_start) begin
                vb_cnt++;
                check_val("vblank_disp", bus_s.o_disp_enbl, 0);
            end
            if (bus_s.o_frame_start) begin
                if (seen > 0) begin
                    check_val("fs_interval_1x", cyc - last_fs, S_TOT);
                    check_val("vblank_per_frame", vb_cnt, 1);
                end
                vb_cnt = 0; last_fs = cyc; seen++;
            end
        end
        check_val("fs_seen_1x", seen, 3);

        // i_pix_en every third clock
        seen = 0;
        for (int i = 0; i < int'(3 * (2 * S_TOT + 8)); i++) begin
            step_s(i % 3 == 0);
            check("third_en", get_s(), model_s());
            if (bus_s.o_frame_start) begin
                if (seen > 0) check_val("fs_interval_3x", cyc - last_fs, 3 * S_TOT);
                last_fs = cyc; seen++;
            end
        end
        check_val("fs_seen_3x", seen, 2);

        // Async reset mid-frame at (10,6)
        guard = 0;
        while (idx_s != 6 * S_HT + 10 && guard < 2 * S_TOT) begin
            step_s(1'b1);
            check("to_mid", get_s(), model_s());
            guard++;
        end
        check_val("mid_h", bus_s.o_h_coord, 10);
        check_val("mid_v", bus_s.o_v_coord, 6);
        #2 rst_s_n = 1'b0;
        idx_s = S_TOT - 1;
        pul_s = 1'b0;
        #1 check("async_reset_small", get_s(), model_s());
        @(negedge clk);
        step_s(1'b1);
        check("held_in_reset", get_s(), model_s());
        rst_s_n = 1'b1;
        step_s(1'b0);
        check("release_hold", get_s(), model_s());
        step_s(1'b1);
        check("restart_small", get_s(), mk(0, 0, 1, !S_HPOL, !S_VPOL, 1, 1, 0));

        // Random i_pix_en until three more frames have started
        fs_cnt = 0; guard = 0;
        while (fs_cnt < 3 && guard < 20000) begin
            step_s(1'($urandom_range(0, 1)));
            check("random_en", get_s(), model_s());
            check_val("coord_range", (bus_s.o_h_coord <= 11'(S_HT - 1)) &&
                                     (bus_s.o_v_coord <= 10'(S_VT - 1)), 1);
            if (bus_s.o_frame_start) fs_cnt++;
            guard++;
        end
        check_val("random_3_frames", fs_cnt, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
